// File: rtl/toggle_handshake_rx.sv
// Destination side of a toggle-based clock-domain-crossing handshake: synchronizes
// the request toggle, captures the held source word and returns an acknowledge toggle.
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_b,
  input  logic              rst_n,
  input  logic              req_tog,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tog,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       xfer_cnt,
  input  logic              clr_err,
  output logic              err_overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_seen_r;
  state_t                 state_r;
  logic                   req_sync_s;
  logic                   req_event_s;

  // Only the last synchronizer stage may feed logic; earlier stages can be metastable.
  assign req_sync_s  = sync_r[SYNC_STAGES-1];
  assign req_event_s = req_sync_s ^ req_seen_r;

  // Request toggle synchronizer chain.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_tog};
    end
  end

  // Capture / hold / acknowledge state machine with sticky overrun flag.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_seen_r  <= 1'b0;
      ack_tog     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= {DATA_W{1'b0}};
      xfer_cnt    <= 16'h0000;
      err_overrun <= 1'b0;
    end else begin
      // Clear first so that a same-edge overrun below takes precedence.
      if (clr_err) begin
        err_overrun <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (req_event_s) begin
            out_data   <= req_data;
            out_valid  <= 1'b1;
            req_seen_r <= req_sync_s;
            state_r    <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ack_tog   <= ~ack_tog;
            xfer_cnt  <= xfer_cnt + 16'd1;
            state_r   <= IDLE;
          end
          // A new request while a word is still pending is dropped, never acknowledged.
          if (req_event_s) begin
            err_overrun <= 1'b1;
            req_seen_r  <= req_sync_s;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: directed scenarios plus a
// randomized source on an unrelated clock, with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_toggle_handshake_rx;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk_b = 1'b0;
  logic              clk_a = 1'b0;
  logic              rst_n;
  logic              req_tog;
  logic [DATA_W-1:0] req_data;
  logic              ack_tog;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       xfer_cnt;
  logic              clr_err;
  logic              err_overrun;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        ack_sync_a = 2'b00;

  toggle_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .req_tog(req_tog), .req_data(req_data),
    .ack_tog(ack_tog), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .xfer_cnt(xfer_cnt), .clr_err(clr_err),
    .err_overrun(err_overrun)
  );

  always #5 clk_b = ~clk_b;
  always #3.7 clk_a = ~clk_a;

  // Source-side synchronizer for the returned acknowledge toggle.
  always @(posedge clk_a) ack_sync_a <= {ack_sync_a[0], ack_tog};

  task automatic do_reset();
    rst_n = 1'b0; req_tog = 1'b0; req_data = 8'h00; out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk_b);
    @(negedge clk_b);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    req_data = d;
    req_tog  = ~req_tog;
    exp_q.push_back(d);
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] e;
    rst_n = 1'b0; req_tog = 1'b1; req_data = 8'h5A; out_ready = 1'b0; clr_err = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_b);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (ack_tog !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", ack_tog); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", out_data); end
    total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL rst_cnt got=%h want=0000", xfer_cnt); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_overrun); end
    // req_tog already high at release must appear as one new event.
    @(negedge clk_b);
    rst_n = 1'b1;
    exp_q.push_back(8'h5A);
    for (int edge_n = 1; edge_n <= 3; edge_n++) begin
      @(posedge clk_b); #1;
      total++;
      if (out_valid !== (edge_n == 3)) begin
        bad++; $display("FAIL rel_valid edge=%0d got=%b want=%b", edge_n, out_valid, (edge_n == 3));
      end
    end
    e = exp_q.pop_front();
    total++; if (out_data !== e) begin bad++; $display("FAIL rel_data got=%h want=%h", out_data, e); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] e;
    do_reset();
    out_ready = 1'b1;
    send_word(8'hA5);
    for (int edge_n = 1; edge_n <= 2; edge_n++) begin
      @(posedge clk_b); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early edge=%0d got=%b want=0", edge_n, out_valid); end
    end
    @(posedge clk_b); #1;
    e = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    total++; if (out_data !== e) begin bad++; $display("FAIL single_data got=%h want=%h", out_data, e); end
    @(posedge clk_b); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%b want=0", out_valid); end
    total++; if (ack_tog !== 1'b1) begin bad++; $display("FAIL single_ack got=%b want=1", ack_tog); end
    total++; if (xfer_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", xfer_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] e;
    do_reset();
    // Ready with nothing valid must be ignored.
    out_ready = 1'b1;
    repeat (3) @(posedge clk_b);
    #1;
    total++; if (xfer_cnt !== 16'd0 || ack_tog !== 1'b0) begin
      bad++; $display("FAIL idle_ready cnt=%0d ack=%b want cnt=0 ack=0", xfer_cnt, ack_tog);
    end
    @(negedge clk_b);
    out_ready = 1'b0;
    send_word(8'h3C);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_b); #1;
      if (out_valid === 1'b1) break;
    end
    e = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_wait got=%b want=1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_b); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== e || ack_tog !== 1'b0 || xfer_cnt !== 16'd0) begin
        bad++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h ack=%b cnt=%0d want 1 %h 0 0",
                        i, out_valid, out_data, ack_tog, xfer_cnt, e);
      end
    end
    @(negedge clk_b);
    out_ready = 1'b1;
    @(posedge clk_b); #1;
    total++; if (out_valid !== 1'b0 || ack_tog !== 1'b1 || xfer_cnt !== 16'd1) begin
      bad++; $display("FAIL bp_release valid=%b ack=%b cnt=%0d want 0 1 1", out_valid, ack_tog, xfer_cnt);
    end
    repeat (3) @(posedge clk_b);
    #1;
    total++; if (ack_tog !== 1'b1 || xfer_cnt !== 16'd1) begin
      bad++; $display("FAIL bp_single ack=%b cnt=%0d want 1 1", ack_tog, xfer_cnt);
    end
  endtask

  task automatic test_overrun();
    logic [DATA_W-1:0] e;
    do_reset();
    send_word(8'h11);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_b); #1;
      if (out_valid === 1'b1) break;
    end
    e = exp_q.pop_front();
    total++; if (out_data !== e) begin bad++; $display("FAIL ovr_first got=%h want=%h", out_data, e); end
    @(negedge clk_b);
    req_data = 8'h22; req_tog = ~req_tog;
    repeat (4) @(posedge clk_b);
    #1;
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", err_overrun); end
    total++; if (out_valid !== 1'b1 || out_data !== e) begin
      bad++; $display("FAIL ovr_retain valid=%b data=%h want 1 %h", out_valid, out_data, e);
    end
    total++; if (xfer_cnt !== 16'd0 || ack_tog !== 1'b0) begin
      bad++; $display("FAIL ovr_noack cnt=%0d ack=%b want 0 0", xfer_cnt, ack_tog);
    end
    @(negedge clk_b);
    clr_err = 1'b1;
    @(posedge clk_b); #1;
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", err_overrun); end
    // Event landing on the completion edge, together with a clear: set wins.
    @(negedge clk_b);
    clr_err = 1'b0; req_data = 8'h33; req_tog = ~req_tog;
    repeat (2) @(posedge clk_b);
    @(negedge clk_b);
    out_ready = 1'b1; clr_err = 1'b1;
    @(posedge clk_b); #1;
    total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_setwins got=%b want=1", err_overrun); end
    total++; if (out_valid !== 1'b0 || ack_tog !== 1'b1 || xfer_cnt !== 16'd1) begin
      bad++; $display("FAIL ovr_complete valid=%b ack=%b cnt=%0d want 0 1 1", out_valid, ack_tog, xfer_cnt);
    end
    @(negedge clk_b);
    clr_err = 1'b0;
    repeat (4) @(posedge clk_b);
    #1;
    total++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd1 || err_overrun !== 1'b1 || out_data !== e) begin
      bad++; $display("FAIL ovr_dropped valid=%b cnt=%0d err=%b data=%h want 0 1 1 %h",
                      out_valid, xfer_cnt, err_overrun, out_data, e);
    end
  endtask

  task automatic test_reset_hold();
    logic [DATA_W-1:0] e;
    do_reset();
    send_word(8'h77);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_b); #1;
      if (out_valid === 1'b1) break;
    end
    e = exp_q.pop_front();
    total++; if (out_valid !== 1'b1 || out_data !== e) begin
      bad++; $display("FAIL rh_hold valid=%b data=%h want 1 %h", out_valid, out_data, e);
    end
    @(negedge clk_b);
    rst_n = 1'b0; req_tog = 1'b0;
    @(posedge clk_b); #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || ack_tog !== 1'b0 ||
                 xfer_cnt !== 16'd0 || err_overrun !== 1'b0) begin
      bad++; $display("FAIL rh_zero valid=%b data=%h ack=%b cnt=%0d err=%b want all 0",
                      out_valid, out_data, ack_tog, xfer_cnt, err_overrun);
    end
    @(negedge clk_b);
    rst_n = 1'b1;
    repeat (6) @(posedge clk_b);
    #1;
    total++; if (out_valid !== 1'b0 || ack_tog !== 1'b0) begin
      bad++; $display("FAIL rh_idle valid=%b ack=%b want 0 0", out_valid, ack_tog);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] e;
    do_reset();
    force dut.xfer_cnt = 16'hFFFF;
    #1;
    release dut.xfer_cnt;
    @(negedge clk_b);
    out_ready = 1'b1;
    send_word(8'hC3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_b); #1;
      if (out_valid === 1'b1) break;
    end
    e = exp_q.pop_front();
    total++; if (out_data !== e) begin bad++; $display("FAIL wrap_data got=%h want=%h", out_data, e); end
    @(posedge clk_b); #1;
    total++; if (xfer_cnt !== 16'h0000 || err_overrun !== 1'b0 || ack_tog !== 1'b1) begin
      bad++; $display("FAIL wrap_cnt cnt=%h err=%b ack=%b want 0000 0 1", xfer_cnt, err_overrun, ack_tog);
    end
  endtask

  task automatic test_back_to_back();
    int received = 0;
    do_reset();
    fork
      begin : source
        logic [DATA_W-1:0] d;
        int n;
        for (int i = 0; i < 1000; i++) begin
          @(posedge clk_a);
          repeat ($urandom_range(0, 3)) @(posedge clk_a);
          #0.5;
          d = DATA_W'($urandom);
          send_word(d);
          n = 0;
          while (ack_sync_a[1] !== req_tog && n < 200) begin
            @(posedge clk_a);
            n++;
          end
          if (ack_sync_a[1] !== req_tog) begin
            total++; bad++;
            $display("FAIL b2b_ack_timeout word=%0d ack=%b want=%b", i, ack_sync_a[1], req_tog);
            break;
          end
        end
      end
      begin : sink
        logic [DATA_W-1:0] e;
        int cyc = 0;
        while (received < 1000 && cyc < 40000) begin
          @(negedge clk_b);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL b2b_unexpected data=%h want none", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) begin
                bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", received, out_data, e);
              end
            end
            received++;
          end
        end
      end
    join
    repeat (4) @(posedge clk_b);
    #1;
    total++; if (received != 1000) begin bad++; $display("FAIL b2b_count got=%0d want=1000", received); end
    total++; if (xfer_cnt !== 16'd1000) begin bad++; $display("FAIL b2b_cnt got=%0d want=1000", xfer_cnt); end
    total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", err_overrun); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_reset_hold();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
